// File: rtl/mul_pkg.sv
// Shared state encoding for the sequential arithmetic units (multiplier and divider).
// One-hot states so a common controller can mux either unit on the same state bus.
package mul_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper half,
// then shift the whole accumulator right by one.
module mul_step #(
    parameter int N = 4
) (
    input  logic [2*N:0] acc_i,
    input  logic [N-1:0] mcand_i,
    output logic [2*N:0] acc_o
);

    logic [N:0]   upper;
    logic [2*N:0] summed;

    // The (N+1)-bit upper field has room for the carry, so the add never wraps.
    always_comb begin
        upper  = acc_i[2*N:N] + (acc_i[0] ? {1'b0, mcand_i} : {(N+1){1'b0}});
        summed = {upper, acc_i[N-1:0]};
        acc_o  = {1'b0, summed[2*N:1]};
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// fixed N+1 cycles from accepted start to done.
module mul_seq
    import mul_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p,
    output logic           busy,
    output logic           done,
    output logic           overflow
);

    state_e        state_q, state_d;
    logic [2*N:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*N:0]  accStep;

    mul_step #(.N(N)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (accStep)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d = x;
                    acc_d   = {{(N+1){1'b0}}, y};
                    cnt_d   = CW'(N);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = accStep;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            // A corrupted state register recovers to a clean IDLE.
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                mcand_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign p        = acc_q[2*N-1:0];
    assign busy     = (state_q == S_CALC);
    assign done     = (state_q == S_DONE);
    assign overflow = done & (|acc_q[2*N-1:N]);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed steps plus an exhaustive operand sweep,
// with products and flags predicted by a scoreboard queue.
module tb_mul_seq;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] p;
    logic           busy;
    logic           done;
    logic           overflow;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [2*N-1:0] prod;
        logic           ovf;
    } expect_t;

    expect_t scoreQ[$];

    mul_seq #(.N(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .y        (y),
        .p        (p),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic checkVec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse and record the predicted result.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        int prod;
        expect_t e;
        @(negedge clock);
        x     = a;
        y     = b;
        start = 1'b1;
        prod  = int'(a) * int'(b);
        e.prod = 8'(prod);
        e.ovf  = (prod > 15);
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input bit seen, input int lat, input int busyCnt);
        expect_t e;
        checkVec("doneReached", 16'(seen), 16'd1);
        checkVec("latency", 16'(lat), 16'(N + 1));
        checkVec("busyCycles", 16'(busyCnt), 16'(N));
        if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkVec("product", 16'(p), 16'(e.prod));
            checkVec("overflow", 16'(overflow), 16'(e.ovf));
        end else begin
            checkVec("scoreboardUnderflow", 16'(scoreQ.size()), 16'd1);
        end
    endtask

    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input bit disturb);
        int lat;
        int busyCnt;
        bit seen;
        lat     = 0;
        busyCnt = 0;
        seen    = 1'b0;
        applyStimulus(a, b);
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clock);
            if (k == 1) begin
                checkVec("doneDropsOnStart", 16'(done), 16'd0);
                checkVec("busyRises", 16'(busy), 16'd1);
            end
            if (disturb && k == 2) begin
                start = 1'b1;
                x     = 4'($urandom);
                y     = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            checkVec("busyDoneExclusive", 16'(busy & done), 16'd0);
            if (busy) busyCnt++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        start = 1'b0;
        checkOutput(seen, lat, busyCnt);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        #3;
        checkVec("resetP", 16'(p), 16'd0);
        checkVec("resetBusy", 16'(busy), 16'd0);
        checkVec("resetDone", 16'(done), 16'd0);
        checkVec("resetOverflow", 16'(overflow), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkVec("idleBusy", 16'(busy), 16'd0);
        checkVec("idleDone", 16'(done), 16'd0);

        runOp(4'd3, 4'd5, 1'b0);
        checkVec("p_3x5", 16'(p), 16'h0F);
        checkVec("ovf_3x5", 16'(overflow), 16'd0);

        runOp(4'd15, 4'd15, 1'b0);
        checkVec("p_15x15", 16'(p), 16'hE1);
        checkVec("ovf_15x15", 16'(overflow), 16'd1);

        runOp(4'd0, 4'd9, 1'b0);
        checkVec("p_0x9", 16'(p), 16'h00);
        runOp(4'd9, 4'd0, 1'b0);
        checkVec("p_9x0", 16'(p), 16'h00);
        checkVec("ovf_9x0", 16'(overflow), 16'd0);

        runOp(4'd7, 4'd6, 1'b1);
        checkVec("p_7x6_ignoresStart", 16'(p), 16'h2A);
        @(negedge clock);
        checkVec("doneHolds", 16'(done), 16'd1);
        checkVec("pHolds", 16'(p), 16'h2A);

        runOp(4'd2, 4'd8, 1'b0);
        checkVec("p_2x8", 16'(p), 16'h10);
        checkVec("ovf_2x8", 16'(overflow), 16'd1);

        @(negedge clock);
        x     = 4'd13;
        y     = 4'd11;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkVec("asyncResetP", 16'(p), 16'd0);
        checkVec("asyncResetBusy", 16'(busy), 16'd0);
        checkVec("asyncResetDone", 16'(done), 16'd0);
        checkVec("asyncResetOverflow", 16'(overflow), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        runOp(4'd13, 4'd11, 1'b0);
        checkVec("p_13x11", 16'(p), 16'h8F);
        checkVec("ovf_13x11", 16'(overflow), 16'd1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                runOp(4'(a), 4'(b), 1'b0);
            end
        end

        checkVec("scoreboardEmpty", 16'(scoreQ.size()), 16'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
